// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of one single-port 32x32 ram.
// One access is in flight at a time; every output comes straight from a flop.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter bit RR     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              busy,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                last_r, last_nxt_s;
  logic                owner_r, owner_nxt_s;
  logic                win_s;
  logic                busy_r, busy_nxt_s;
  logic                cen_r, cen_nxt_s;
  logic                wen_r, wen_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [DATA_W-1:0]   din_r, din_nxt_s;
  logic                gnt0_r, gnt0_nxt_s;
  logic                gnt1_r, gnt1_nxt_s;
  logic                rvalid0_r, rvalid0_nxt_s;
  logic                rvalid1_r, rvalid1_nxt_s;
  logic [DATA_W-1:0]   rdata0_r, rdata0_nxt_s;
  logic [DATA_W-1:0]   rdata1_r, rdata1_nxt_s;

  // Winner select: 1 = M1. Round-robin favours whoever was not granted last.
  always_comb begin
    if (m0_req && m1_req) begin
      if (RR) begin
        win_s = ~last_r;
      end else begin
        win_s = 1'b0;
      end
    end else if (m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    last_nxt_s    = last_r;
    owner_nxt_s   = owner_r;
    cen_nxt_s     = 1'b0;
    wen_nxt_s     = 1'b0;
    addr_nxt_s    = addr_r;
    din_nxt_s     = din_r;
    gnt0_nxt_s    = 1'b0;
    gnt1_nxt_s    = 1'b0;
    rvalid0_nxt_s = 1'b0;
    rvalid1_nxt_s = 1'b0;
    rdata0_nxt_s  = rdata0_r;
    rdata1_nxt_s  = rdata1_r;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt_s = CMD;
          cen_nxt_s   = 1'b1;
          owner_nxt_s = win_s;
          last_nxt_s  = win_s;
          if (win_s) begin
            wen_nxt_s  = m1_wr;
            addr_nxt_s = m1_addr;
            din_nxt_s  = m1_wdata;
            gnt1_nxt_s = 1'b1;
          end else begin
            wen_nxt_s  = m0_wr;
            addr_nxt_s = m0_addr;
            din_nxt_s  = m0_wdata;
            gnt0_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CMD: begin
        // wen_r still holds the direction of the command just issued
        if (wen_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RDWAIT;
        end
      end
      RDWAIT: begin
        state_nxt_s = IDLE;
        if (owner_r) begin
          rdata1_nxt_s  = ram_dout;
          rvalid1_nxt_s = 1'b1;
        end else begin
          rdata0_nxt_s  = ram_dout;
          rvalid0_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // busy covers the full occupancy window: grant edge up to the edge the next grant may occur
    busy_nxt_s = (state_r != IDLE) || (state_nxt_s != IDLE);
  end

  // FSM state and arbitration history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      owner_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  // Registered ram command, grants, read returns and busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r    <= 1'b0;
      cen_r     <= 1'b0;
      wen_r     <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      din_r     <= {DATA_W{1'b0}};
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DATA_W{1'b0}};
      rdata1_r  <= {DATA_W{1'b0}};
    end else begin
      busy_r    <= busy_nxt_s;
      cen_r     <= cen_nxt_s;
      wen_r     <= wen_nxt_s;
      addr_r    <= addr_nxt_s;
      din_r     <= din_nxt_s;
      gnt0_r    <= gnt0_nxt_s;
      gnt1_r    <= gnt1_nxt_s;
      rvalid0_r <= rvalid0_nxt_s;
      rvalid1_r <= rvalid1_nxt_s;
      rdata0_r  <= rdata0_nxt_s;
      rdata1_r  <= rdata1_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign ram_cen   = cen_r;
  assign ram_wen   = wen_r;
  assign ram_addr  = addr_r;
  assign ram_din   = din_r;
  assign m0_gnt    = gnt0_r;
  assign m1_gnt    = gnt1_r;
  assign m0_rvalid = rvalid0_r;
  assign m1_rvalid = rvalid1_r;
  assign m0_rdata  = rdata0_r;
  assign m1_rdata  = rdata1_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance and a fixed-priority
// instance, each backed by a behavioural 32x32 ram with registered dout.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_clr;
  int          errors = 0;
  int          checks = 0;

  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [4:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        busy, ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic        f_m0_req, f_m0_wr, f_m1_req, f_m1_wr;
  logic [4:0]  f_m0_addr, f_m1_addr;
  logic [31:0] f_m0_wdata, f_m1_wdata;
  logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_busy, f_ram_cen, f_ram_wen;
  logic [4:0]  f_ram_addr;
  logic [31:0] f_ram_din, f_ram_dout;

  logic [31:0] mem  [0:31];
  logic [31:0] fmem [0:31];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(5), .DATA_W(32), .RR(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .busy(busy), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram_arbiter #(.ADDR_W(5), .DATA_W(32), .RR(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(f_m0_req), .m0_wr(f_m0_wr), .m0_addr(f_m0_addr), .m0_wdata(f_m0_wdata),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_wr(f_m1_wr), .m1_addr(f_m1_addr), .m1_wdata(f_m1_wdata),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
    .busy(f_busy), .ram_cen(f_ram_cen), .ram_wen(f_ram_wen), .ram_addr(f_ram_addr),
    .ram_din(f_ram_din), .ram_dout(f_ram_dout)
  );

  // Behavioural ram behind the round-robin instance.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (ram_cen) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      else         ram_dout <= mem[ram_addr];
    end
  end

  // Behavioural ram behind the fixed-priority instance, preloaded with two words.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) fmem[i] <= 32'h0;
      fmem[7] <= 32'hA5A5_0F0F;
      fmem[9] <= 32'h0BAD_F00D;
    end else if (f_ram_cen) begin
      if (f_ram_wen) fmem[f_ram_addr] <= f_ram_din;
      else           f_ram_dout <= fmem[f_ram_addr];
    end
  end

  task automatic test_reset;
    checks++; if ({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, busy, ram_cen, ram_wen} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000", {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, busy, ram_cen, ram_wen}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    checks++; if ({ram_addr, ram_din} !== 37'h0) begin
      errors++; $display("FAIL reset_cmd: got %h want 0", {ram_addr, ram_din}); end
    checks++; if ({f_busy, f_ram_cen, f_m0_gnt, f_m1_gnt} !== 4'b0) begin
      errors++; $display("FAIL reset_fp: got %b want 0000", {f_busy, f_ram_cen, f_m0_gnt, f_m1_gnt}); end
  endtask

  task automatic test_write;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 5'd3; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt, ram_cen, ram_wen, busy} !== 5'b10111) begin
      errors++; $display("FAIL wr_t0_ctrl: got %b want 10111", {m0_gnt, m1_gnt, ram_cen, ram_wen, busy}); end
    checks++; if (ram_addr !== 5'd3 || ram_din !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_t0_cmd: got %h/%h want 03/deadbeef", ram_addr, ram_din); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({m0_gnt, ram_cen, ram_wen, busy} !== 4'b0001) begin
      errors++; $display("FAIL wr_t1_ctrl: got %b want 0001", {m0_gnt, ram_cen, ram_wen, busy}); end
    checks++; if (ram_addr !== 5'd3) begin
      errors++; $display("FAIL wr_t1_addr_hold: got %h want 03", ram_addr); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_t2_busy: got %b want 0", busy); end
  endtask

  task automatic test_read;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 5'd3;
    @(negedge clk);
    checks++; if ({m1_gnt, m0_gnt, ram_cen, ram_wen, busy} !== 5'b10101) begin
      errors++; $display("FAIL rd_t0_ctrl: got %b want 10101", {m1_gnt, m0_gnt, ram_cen, ram_wen, busy}); end
    m1_req = 1'b0;
    @(negedge clk);
    checks++; if ({m1_rvalid, m1_gnt, busy} !== 3'b001) begin
      errors++; $display("FAIL rd_t1: got %b want 001", {m1_rvalid, m1_gnt, busy}); end
    @(negedge clk);
    checks++; if ({m1_rvalid, busy} !== 2'b11 || m1_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_t2_data: got %b/%h want 11/deadbeef", {m1_rvalid, busy}, m1_rdata); end
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_t2_m0_untouched: got %b/%h want 0/0", m0_rvalid, m0_rdata); end
    @(negedge clk);
    checks++; if ({m1_rvalid, busy} !== 2'b00 || m1_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_t3_hold: got %b/%h want 00/deadbeef", {m1_rvalid, busy}, m1_rdata); end
  endtask

  task automatic test_boundary;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 5'd31; m0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1 || ram_addr !== 5'd31 || ram_din !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL bnd_wr31: got %b/%h/%h want 1/1f/ffffffff", m0_gnt, ram_addr, ram_din); end
    m0_req = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 5'd0;
    @(negedge clk);
    checks++; if ({m0_gnt, ram_cen, ram_wen} !== 3'b110 || ram_addr !== 5'd0) begin
      errors++; $display("FAIL bnd_rd0_gnt_t2: got %b/%h want 110/00", {m0_gnt, ram_cen, ram_wen}, ram_addr); end
    m0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin
      errors++; $display("FAIL bnd_rd0_data: got %b/%h want 1/00000000", m0_rvalid, m0_rdata); end
    m0_req = 1'b1; m0_addr = 5'd31;
    @(negedge clk);
    checks++; if ({m0_gnt, m0_rvalid} !== 2'b10) begin
      errors++; $display("FAIL bnd_rd31_gnt_t3: got %b want 10", {m0_gnt, m0_rvalid}); end
    m0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL bnd_rd31_data: got %b/%h want 1/ffffffff", m0_rvalid, m0_rdata); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL bnd_rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    logic eg0, eg1, ev0, ev1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 5'd3;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 5'd31;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eg0 = (k % 6 == 0); eg1 = (k % 6 == 3); ev0 = (k % 6 == 2); ev1 = (k % 6 == 5);
      checks++; if ({m0_gnt, m1_gnt} !== {eg0, eg1}) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {m0_gnt, m1_gnt}, {eg0, eg1}); end
      checks++; if ({m0_rvalid, m1_rvalid} !== {ev0, ev1}) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, {m0_rvalid, m1_rvalid}, {ev0, ev1}); end
      if (ev0) begin
        checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL rr_m0_rdata[%0d]: got %h want deadbeef", k, m0_rdata); end
      end
      if (ev1) begin
        checks++; if (m1_rdata !== 32'hFFFF_FFFF) begin
          errors++; $display("FAIL rr_m1_rdata[%0d]: got %h want ffffffff", k, m1_rdata); end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    checks++; if ({busy, m0_gnt, m1_gnt} !== 3'b000) begin
      errors++; $display("FAIL rr_idle: got %b want 000", {busy, m0_gnt, m1_gnt}); end
  endtask

  task automatic test_fixed_priority;
    logic eg0, ev0;
    f_m0_req = 1'b1; f_m0_wr = 1'b0; f_m0_addr = 5'd7;
    f_m1_req = 1'b1; f_m1_wr = 1'b0; f_m1_addr = 5'd9;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eg0 = (k % 3 == 0); ev0 = (k % 3 == 2);
      checks++; if ({f_m0_gnt, f_m1_gnt} !== {eg0, 1'b0}) begin
        errors++; $display("FAIL fp_gnt[%0d]: got %b want %b", k, {f_m0_gnt, f_m1_gnt}, {eg0, 1'b0}); end
      checks++; if ({f_m0_rvalid, f_m1_rvalid} !== {ev0, 1'b0}) begin
        errors++; $display("FAIL fp_rvalid[%0d]: got %b want %b", k, {f_m0_rvalid, f_m1_rvalid}, {ev0, 1'b0}); end
      if (ev0) begin
        checks++; if (f_m0_rdata !== 32'hA5A5_0F0F) begin
          errors++; $display("FAIL fp_m0_rdata[%0d]: got %h want a5a50f0f", k, f_m0_rdata); end
      end
    end
    f_m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({f_m0_gnt, f_m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL fp_m1_after_drop: got %b want 01", {f_m0_gnt, f_m1_gnt}); end
    f_m1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (f_m1_rvalid !== 1'b1 || f_m1_rdata !== 32'h0BAD_F00D || f_m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL fp_m1_data: got %b/%h/%b want 1/0badf00d/0", f_m1_rvalid, f_m1_rdata, f_m0_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 5'd3;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: got %b want 1", m0_gnt); end
    m0_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, ram_cen, ram_wen, m0_gnt, m0_rvalid, m1_gnt, m1_rvalid} !== 7'b0) begin
      errors++; $display("FAIL mid_ctrl_cleared: got %b want 0000000", {busy, ram_cen, ram_wen, m0_gnt, m0_rvalid, m1_gnt, m1_rvalid}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0 || ram_addr !== 5'd0) begin
      errors++; $display("FAIL mid_data_cleared: got %h/%h want 0/0", {m0_rdata, m1_rdata}, ram_addr); end
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_no_rvalid: got %b want 0", m0_rvalid); end
    reset_n = 1'b1;
    m0_req = 1'b1; m0_addr = 5'd3;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 5'd31;
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt, m0_rvalid} !== 3'b100) begin
      errors++; $display("FAIL mid_first_tie_m0: got %b want 100", {m0_gnt, m1_gnt, m0_rvalid}); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; mem_clr = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 5'd0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 5'd0; m1_wdata = 32'h0;
    f_m0_req = 1'b0; f_m0_wr = 1'b0; f_m0_addr = 5'd0; f_m0_wdata = 32'h0;
    f_m1_req = 1'b0; f_m1_wr = 1'b0; f_m1_addr = 5'd0; f_m1_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    reset_n = 1'b1; mem_clr = 1'b0;
    test_write;
    test_read;
    test_boundary;
    test_round_robin;
    test_fixed_priority;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
